// File: rtl/uart_pkg.sv
//==============================================================================
// Module : uart_pkg
// Desc   : Shared UART definitions (frame FSM encoding, width helper).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Counter width that never collapses to zero bits for tiny parameter values.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
//==============================================================================
// Module : uart_rx_if
// Desc   : Parallel consumer-side bus of the UART receiver.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 rdy_clr;
  logic [DATA_BITS-1:0] dout;
  logic                 rdy;
  logic                 frame_err;
  logic                 overrun;
  logic                 rx_busy;

  modport master (
    input  rdy_clr,
    output dout, rdy, frame_err, overrun, rx_busy
  );

  modport slave (
    output rdy_clr,
    input  dout, rdy, frame_err, overrun, rx_busy
  );

endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
//==============================================================================
// Module : sync_2ff
// Desc   : Two-flop synchronizer with a parameterised reset value.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//==============================================================================
// Module : uart_rx
// Desc   : 8N1 UART receiver, 16x oversampled, parallel output with rdy flag.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk_50m,
  input  logic      rst,
  input  logic      rx,
  input  logic      clken,
  uart_rx_if.master bus
);

  localparam int c_cnt_w = clog2_min1(OVERSAMPLE);
  localparam int c_idx_w = clog2_min1(DATA_BITS);

  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(OVERSAMPLE - 1);
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DATA_BITS - 1);

  logic w_rx_s;

  uart_state_t          r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt,   w_cnt_nxt;
  logic [c_idx_w-1:0]   r_idx,   w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0] r_dout,  w_dout_nxt;
  logic                 r_rdy,   w_rdy_nxt;
  logic                 r_ferr,  w_ferr_nxt;
  logic                 r_ovr,   w_ovr_nxt;

  // Idle line is high, so the synchronizer comes out of reset at 1.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk_50m),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_rdy   <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_dout  <= w_dout_nxt;
      r_rdy   <= w_rdy_nxt;
      r_ferr  <= w_ferr_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_dout_nxt  = r_dout;
    w_rdy_nxt   = r_rdy;
    w_ferr_nxt  = r_ferr;
    w_ovr_nxt   = r_ovr;

    // Acknowledge first; a byte completing on the same edge overrides it below.
    if (bus.rdy_clr) begin
      w_rdy_nxt = 1'b0;
      w_ovr_nxt = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (clken && !w_rx_s) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
        end
      end
      START: begin
        if (clken) begin
          if (r_cnt == c_half_last) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_state_nxt = w_rx_s ? IDLE : DATA;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
      end
      DATA: begin
        if (clken) begin
          if (r_cnt == c_bit_last) begin
            w_cnt_nxt          = '0;
            w_shift_nxt[r_idx] = w_rx_s;
            if (r_idx == c_idx_last) begin
              w_state_nxt = STOP;
            end else begin
              w_idx_nxt = r_idx + c_idx_w'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
      end
      STOP: begin
        if (clken) begin
          if (r_cnt == c_bit_last) begin
            // Leave at mid stop bit so the next start edge can be searched for.
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
            if (w_rx_s) begin
              w_dout_nxt = r_shift;
              w_rdy_nxt  = 1'b1;
              w_ferr_nxt = 1'b0;
              w_ovr_nxt  = r_rdy && !bus.rdy_clr;
            end else begin
              w_ferr_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.dout      = r_dout;
  assign bus.rdy       = r_rdy;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
  assign bus.rx_busy   = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//==============================================================================
// Module : tb_uart_rx
// Desc   : Directed bench for uart_rx: clken every 4th clock, 64 clocks per bit.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int BIT_CLKS = 64;
  // Start bit is driven at negedge k=0 aligned so the first sampling tick is posedge 2;
  // the stop sample is 152 ticks (608 clocks) later and is seen at negedge 611.
  localparam int DONE_K   = 611;
  localparam int BUSY_K   = 3;

  logic clk_50m = 1'b0;
  logic rst;
  logic rx;
  logic clken;

  int div;
  int k;
  int busy_first, busy_fall, rdy_rise;
  int checks   = 0;
  int failures = 0;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .rx      (rx),
    .clken   (clken),
    .bus     (bus.master)
  );

  always #10 clk_50m = ~clk_50m;

  initial begin
    div   = 0;
    clken = 1'b0;
    forever begin
      @(negedge clk_50m);
      div   = (div + 1) % 4;
      clken = (div == 0);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    bit         clr;
    logic [7:0] exp_dout;
    logic       exp_rdy;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold_bit(input logic v, input int clr_at);
    rx = v;
    for (int n = 0; n < BIT_CLKS; n++) begin
      bus.rdy_clr = (k == clr_at);
      @(negedge clk_50m);
      k++;
      if (busy_first < 0 && bus.rx_busy) busy_first = k;
      if (busy_first >= 0 && busy_fall < 0 && !bus.rx_busy) busy_fall = k;
      if (rdy_rise < 0 && bus.rdy) rdy_rise = k;
    end
    bus.rdy_clr = 1'b0;
  endtask

  task automatic align_start();
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk_50m);
    @(posedge clk_50m);
    while (div != 1) @(posedge clk_50m);
    @(negedge clk_50m);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input bit align,
                            input int nbits, input int clr_at);
    if (align) align_start();
    k          = 0;
    busy_first = -1;
    busy_fall  = -1;
    rdy_rise   = -1;
    hold_bit(1'b0, clr_at);
    for (int b = 0; b < nbits; b++) hold_bit(data[b], clr_at);
    if (nbits == 8) hold_bit(stop, clr_at);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk_50m);
    bus.rdy_clr = 1'b1;
    @(negedge clk_50m);
    bus.rdy_clr = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] d, input logic r,
                            input logic fe, input logic ov);
    check({tag, " dout"},      bus.dout,          d);
    check({tag, " rdy"},       8'(bus.rdy),       8'(r));
    check({tag, " frame_err"}, 8'(bus.frame_err), 8'(fe));
    check({tag, " overrun"},   8'(bus.overrun),   8'(ov));
  endtask

  initial begin
    //            data   stop  clr   dout   rdy   ferr  ovr
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h6B, 1'b1, 1'b1, 8'h6B, 1'b1, 1'b0, 1'b0};

    rst         = 1'b1;
    rx          = 1'b1;
    bus.rdy_clr = 1'b0;
    repeat (3) @(negedge clk_50m);
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset rx_busy", 8'(bus.rx_busy), 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].clr) pulse_clr();
      send_frame(vecs[i].data, vecs[i].stop, 1'b1, 8, -1);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_rdy,
                 vecs[i].exp_ferr, vecs[i].exp_ovr);
      check_int($sformatf("vec%0d busy_rise", i), busy_first, BUSY_K);
      check_int($sformatf("vec%0d busy_fall", i), busy_fall, DONE_K);
      if (vecs[i].clr && vecs[i].stop) check_int($sformatf("vec%0d rdy_rise", i), rdy_rise, DONE_K);
    end

    // Start-bit glitch: five low ticks, rejected at the mid-start sample.
    pulse_clr();
    align_start();
    rx = 1'b0;
    repeat (10) @(negedge clk_50m);
    check("glitch busy", 8'(bus.rx_busy), 8'h01);
    repeat (10) @(negedge clk_50m);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk_50m);
    check("glitch idle", 8'(bus.rx_busy), 8'h00);
    check_outs("glitch", 8'h6B, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames without acknowledge.
    pulse_clr();
    send_frame(8'h11, 1'b1, 1'b1, 8, -1);
    check_outs("b2b first", 8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 8, -1);
    check_outs("b2b second", 8'h22, 1'b1, 1'b0, 1'b1);
    pulse_clr();
    check_outs("b2b ack", 8'h22, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame.
    send_frame(8'hF0, 1'b1, 1'b1, 4, -1);
    check("midframe busy", 8'(bus.rx_busy), 8'h01);
    #3;
    rst = 1'b1;
    #1;
    check_outs("async rst", 8'h00, 1'b0, 1'b0, 1'b0);
    check("async rst rx_busy", 8'(bus.rx_busy), 8'h00);
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b1, 8, -1);
    check_outs("after rst", 8'h5A, 1'b1, 1'b0, 1'b0);

    // Acknowledge lands on the completion edge: set wins, no overrun.
    send_frame(8'h7E, 1'b1, 1'b1, 8, DONE_K - 1);
    check_outs("clr on done", 8'h7E, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
